// File: rtl/pixel_seq_pkg.sv
// rtl/pixel_seq_pkg.sv - shared constants for the pixel readout sequencer
package pixel_seq_pkg;

  localparam int DEF_N_PIX = 12;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_T_SEL = 2;
  localparam int DEF_T_RST = 4;
  localparam int DEF_T_SH  = 3;
  localparam int DEF_T_CMP = 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEL  = 3'd1;
  localparam logic [2:0] S_RST  = 3'd2;
  localparam logic [2:0] S_INT  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_SH   = 3'd5;
  localparam logic [2:0] S_CMP  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

endpackage

// File: rtl/cmp_sync.sv
// rtl/cmp_sync.sv - two-flop synchronizer for the asynchronous comparator output
module cmp_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pixel_readout_seq.sv
// rtl/pixel_readout_seq.sv - per-pixel phase sequencer for the photodiode readout chain
// Optional PIX_MASK_EN adds a pix_mask input that skips masked pixels.
module pixel_readout_seq
  import pixel_seq_pkg::*;
#(
  parameter int N_PIX = DEF_N_PIX,
  parameter int CNT_W = DEF_CNT_W,
  parameter int T_SEL = DEF_T_SEL,
  parameter int T_RST = DEF_T_RST,
  parameter int T_SH  = DEF_T_SH,
  parameter int T_CMP = DEF_T_CMP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] int_cycles,
`ifdef PIX_MASK_EN
  input  logic [N_PIX-1:0] pix_mask,
`endif
  input  logic             cmp_in,
  output logic             busy,
  output logic             done,
  output logic [N_PIX-1:0] result,
  output logic [N_PIX-1:0] pd_a,
  output logic [N_PIX-1:0] pd_b,
  output logic             sw1,
  output logic             sw2,
  output logic             sh_rst,
  output logic             sh,
  output logic             sh_cmp
);

  localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] int_q, int_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_PIX-1:0] result_q, result_d;
  logic             cmp_s;
  logic             phase_end;
  logic             first_ok, next_ok;
  logic [IDX_W-1:0] first_idx, next_idx;
  logic [N_PIX-1:0] pix_sel;

  cmp_sync u_cmp_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (cmp_s)
  );

`ifdef PIX_MASK_EN
  logic [N_PIX-1:0] mask_q, mask_d;

  // Lowest unmasked pixel at or above 'from'; MSB flags that one exists.
  function automatic logic [IDX_W:0] next_pix(input logic [N_PIX-1:0] m, input int from);
    next_pix = '0;
    for (int i = N_PIX - 1; i >= 0; i--) begin
      if (i >= from && !m[i]) next_pix = {1'b1, IDX_W'(i)};
    end
  endfunction

  always_comb begin
    mask_d = (state_q == S_IDLE && start && !abort) ? pix_mask : mask_q;
    {first_ok, first_idx} = next_pix(pix_mask, 0);
    {next_ok, next_idx}   = next_pix(mask_q, int'(idx_q) + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end
`else
  always_comb begin
    first_ok  = 1'b1;
    first_idx = '0;
    next_ok   = (idx_q != IDX_W'(N_PIX - 1));
    next_idx  = idx_q + 1'b1;
  end
`endif

  assign phase_end = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = phase_end ? '0 : cnt_q - 1'b1;
    int_d    = int_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          int_d    = int_cycles;
          result_d = '0;
          idx_d    = first_idx;
          if (first_ok) begin
            state_d = S_SEL;
            cnt_d   = CNT_W'(T_SEL - 1);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SEL: if (phase_end) begin
        state_d = S_RST;
        cnt_d   = CNT_W'(T_RST - 1);
      end
      S_RST: if (phase_end) begin
        state_d = S_INT;
        cnt_d   = (int_q == '0) ? '0 : int_q - 1'b1;
      end
      S_INT: if (phase_end) begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: if (phase_end) begin
        state_d = S_SH;
        cnt_d   = CNT_W'(T_SH - 1);
      end
      S_SH: if (phase_end) begin
        state_d = S_CMP;
        cnt_d   = CNT_W'(T_CMP - 1);
      end
      S_CMP: if (phase_end) begin
        result_d[idx_q] = cmp_s;
        if (next_ok) begin
          idx_d   = next_idx;
          state_d = S_SEL;
          cnt_d   = CNT_W'(T_SEL - 1);
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort overrides everything, including a start seen in the same IDLE cycle.
    if (abort) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      int_d    = int_q;
      idx_d    = idx_q;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      int_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      int_q    <= int_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  assign pix_sel = N_PIX'(1) << idx_q;

  always_comb begin
    busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    done   = (state_q == S_DONE);
    pd_a   = (state_q == S_SEL || state_q == S_RST || state_q == S_INT) ? pix_sel : '0;
    pd_b   = (state_q == S_SH || state_q == S_CMP) ? pix_sel : '0;
    sw1    = (state_q == S_RST);
    sw2    = (state_q == S_INT);
    sh_rst = (state_q == S_RST);
    sh     = (state_q == S_SH);
    sh_cmp = (state_q == S_CMP);
    result = result_q;
  end

endmodule

// File: tb/tb_pixel_readout_seq.sv
// tb/tb_pixel_readout_seq.sv - directed self-checking bench for pixel_readout_seq
module tb_pixel_readout_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort, cmp_in;
  logic [15:0] int_cycles;
`ifdef PIX_MASK_EN
  logic [11:0] pix_mask;
`endif
  logic        busy, done, sw1, sw2, sh_rst, sh, sh_cmp;
  logic [11:0] result, pd_a, pd_b;

  int checks = 0;
  int errors = 0;
  int n, sw2_n, bad, cnt;

  pixel_readout_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .int_cycles (int_cycles),
`ifdef PIX_MASK_EN
    .pix_mask   (pix_mask),
`endif
    .cmp_in     (cmp_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .pd_a       (pd_a),
    .pd_b       (pd_b),
    .sw1        (sw1),
    .sw2        (sw2),
    .sh_rst     (sh_rst),
    .sh         (sh),
    .sh_cmp     (sh_cmp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ctrl();
    return {busy, done, sw1, sw2, sh_rst, sh, sh_cmp};
  endfunction

  task automatic start_scan(input logic [15:0] ic);
    int_cycles = ic;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs until done; cmp_in follows the pattern bit of the pixel being read out.
  task automatic run_to_done(input logic [11:0] pat, input bit spam,
                             output int n_o, output int sw2_o, output int bad_o);
    n_o = 1; sw2_o = 0; bad_o = 0;
    while (!done && n_o < 2000) begin
      if (!$onehot0(pd_a) || !$onehot0(pd_b) || (|pd_a && |pd_b) || (sw1 && sw2) || !busy)
        bad_o++;
      if (sw2) sw2_o++;
      if (|pd_b) cmp_in = |(pd_b & pat);
      start = spam && n_o >= 10 && n_o < 100;
      tick();
      n_o++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmp_in = 1'b0; int_cycles = '0;
`ifdef PIX_MASK_EN
    pix_mask = '0;
`endif
    tick(); tick();
    check("reset_ctrl", 32'(ctrl()), 32'h0);
    check("reset_pd", {8'h0, pd_a, pd_b}, 32'h0);
    check("reset_result", 32'(result), 32'h0);
    rst = 1'b0;
    tick();

    // Full scan, int_cycles=10, comparator always high
    start_scan(16'd10);
    check("full_busy_k1", 32'(busy), 32'h1);
    check("full_pd_a_k1", 32'(pd_a), 32'h001);
    run_to_done(12'hFFF, 1'b0, n, sw2_n, bad);
    check("full_done_at", 32'(n), 32'd265);
    check("full_done", 32'(done), 32'h1);
    check("full_result", 32'(result), 32'hFFF);
    check("full_sw2_cycles", 32'(sw2_n), 32'd120);
    check("full_invariants", 32'(bad), 32'h0);
    tick();
    check("full_done_pulse", 32'({busy, done}), 32'h0);

    // Bit pattern with int_cycles=3 (15 cycles per pixel)
    start_scan(16'd3);
    run_to_done(12'hA5C, 1'b0, n, sw2_n, bad);
    check("pat_done_at", 32'(n), 32'd181);
    check("pat_result", 32'(result), 32'hA5C);
    check("pat_invariants", 32'(bad), 32'h0);
    tick();

    // int_cycles=0 behaves as 1, with start held during the scan
    start_scan(16'd0);
    run_to_done(12'h5A3, 1'b1, n, sw2_n, bad);
    check("int0_done_at", 32'(n), 32'd157);
    check("int0_sw2_cycles", 32'(sw2_n), 32'd12);
    check("int0_result", 32'(result), 32'h5A3);
    check("int0_invariants", 32'(bad), 32'h0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) cnt++;
    end
    check("int0_single_done", 32'(cnt), 32'h0);

    // Abort during INT of pixel 5
    cmp_in = 1'b1;
    start_scan(16'd10);
    cnt = 0;
    while (!(pd_a[5] && sw2) && cnt < 500) begin
      tick();
      cnt++;
    end
    check("abort_reached_int5", 32'(pd_a[5] && sw2), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ctrl", 32'(ctrl()), 32'h0);
    check("abort_pd", {8'h0, pd_a, pd_b}, 32'h0);
    check("abort_result", 32'(result), 32'h01F);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) cnt++;
    end
    check("abort_no_done", 32'(cnt), 32'h0);

    // Abort and start together in IDLE: start is dropped
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 32'(busy), 32'h0);
    check("abort_start_result", 32'(result), 32'h01F);

    // New start accepted, then synchronous reset during CMP of pixel 2
    start_scan(16'd0);
    check("restart_busy", 32'(busy), 32'h1);
    check("restart_result_clr", 32'(result), 32'h0);
    cnt = 0;
    while (!(sh_cmp && pd_b[2]) && cnt < 500) begin
      tick();
      cnt++;
    end
    check("rst_pre_result", 32'(result), 32'h003);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ctrl", 32'(ctrl()), 32'h0);
    check("rst_pd", {8'h0, pd_a, pd_b}, 32'h0);
    check("rst_result", 32'(result), 32'h0);
    tick();

`ifdef PIX_MASK_EN
    pix_mask = 12'hFF0;
    start_scan(16'd10);
    pix_mask = 12'h000;
    run_to_done(12'hFFF, 1'b0, n, sw2_n, bad);
    check("mask_done_at", 32'(n), 32'd89);
    check("mask_result", 32'(result), 32'h00F);
    check("mask_sw2_cycles", 32'(sw2_n), 32'd40);
    tick();
    pix_mask = 12'hFFF;
    start_scan(16'd10);
    check("mask_all_done", 32'({busy, done}), 32'h1);
    check("mask_all_result", 32'(result), 32'h0);
    tick();
    check("mask_all_idle", 32'({busy, done}), 32'h0);
    pix_mask = 12'h000;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
